// File: rtl/shift_stage.sv
// Purpose : one-operand barrel shifter (4 ops) feeding a 2-entry output FIFO, with a saturating pop counter.
// Latency : 1 cycle from accept to out_valid when the buffer is empty; one result per cycle sustained.
// Backpressure: in_ready comes from registered occupancy only (low when FULL, during flush and in reset);
//               out_ready never reaches in_ready combinationally, and the head stays stable while out_ready is low.
// Ports:
//   clk, rst_n (async active-low), flush (sync clear of buffered results)
//   in_valid/in_ready/in_data/in_amt/in_op : operand handshake; op 00/10 <<, 01 >>, 11 >>>
//   out_valid/out_ready/out_data           : result handshake from the buffer head
//   ops_done                               : results popped downstream, saturates at 16'hFFFF
module shift_stage #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2   // only 2 is supported: pointers are one bit wide
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      ops_done
);

  // Buffer occupancy doubles as the state: EMPTY / ONE / FULL.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             run_en;   // set at the first edge after reset release
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] shift_res;
  logic             push;
  logic             pop;
  logic             amt_big;

  assign in_ready  = run_en && (count != FULL) && !flush;
  assign out_valid = (count != EMPTY);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Shifts of WIDTH or more are handled explicitly so the result does not
  // depend on how wide the amount field happens to be relative to WIDTH.
  assign amt_big = (int'(in_amt) >= WIDTH);

  always_comb begin
    shift_res = in_data;
    case (in_op)
      2'b00, 2'b10: shift_res = amt_big ? '0 : (in_data << in_amt);
      2'b01:        shift_res = amt_big ? '0 : (in_data >> in_amt);
      2'b11:        shift_res = amt_big ? {WIDTH{in_data[WIDTH-1]}}
                                        : $unsigned($signed(in_data) >>> in_amt);
      default:      shift_res = in_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      run_en   <= 1'b0;
      ops_done <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      run_en <= 1'b1;

      // A pop on a flush edge still counts as delivered.
      if (pop && (ops_done != 16'hFFFF)) begin
        ops_done <= ops_done + 16'd1;
      end

      if (flush) begin
        // in_ready is low during flush, so no push can coincide with it.
        count  <= EMPTY;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= shift_res;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10: begin
            case (count)
              EMPTY:   count <= ONE;
              default: count <= FULL;
            endcase
          end
          2'b01: begin
            case (count)
              FULL:    count <= ONE;
              default: count <= EMPTY;
            endcase
          end
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_stage.sv
// Purpose : directed self-checking bench for shift_stage.
// Latency : n/a (bench).
// Backpressure: stalls and releases out_ready explicitly around the buffer-full cases.
module tb_shift_stage;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic [3:0] in_amt;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [15:0] ops_done;

  int n_chk;
  int n_pass;

  shift_stage #(.WIDTH(9), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle; inputs set after this apply to the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed shift vectors: data, amt, op, expected result.
  logic [8:0] v_data [11];
  logic [3:0] v_amt  [11];
  logic [1:0] v_op   [11];
  logic [8:0] v_exp  [11];

  initial begin
    int errs;

    v_data[0]  = 9'h1A5; v_amt[0]  = 4'd3;  v_op[0]  = 2'b00; v_exp[0]  = 9'h128;
    v_data[1]  = 9'h1A5; v_amt[1]  = 4'd3;  v_op[1]  = 2'b01; v_exp[1]  = 9'h034;
    v_data[2]  = 9'h1A5; v_amt[2]  = 4'd3;  v_op[2]  = 2'b10; v_exp[2]  = 9'h128;
    v_data[3]  = 9'h1A5; v_amt[3]  = 4'd3;  v_op[3]  = 2'b11; v_exp[3]  = 9'h1F4;
    v_data[4]  = 9'h100; v_amt[4]  = 4'd9;  v_op[4]  = 2'b11; v_exp[4]  = 9'h1FF;
    v_data[5]  = 9'h100; v_amt[5]  = 4'd15; v_op[5]  = 2'b01; v_exp[5]  = 9'h000;
    v_data[6]  = 9'h0AA; v_amt[6]  = 4'd0;  v_op[6]  = 2'b00; v_exp[6]  = 9'h0AA;
    v_data[7]  = 9'h0AA; v_amt[7]  = 4'd0;  v_op[7]  = 2'b01; v_exp[7]  = 9'h0AA;
    v_data[8]  = 9'h0AA; v_amt[8]  = 4'd0;  v_op[8]  = 2'b10; v_exp[8]  = 9'h0AA;
    v_data[9]  = 9'h0AA; v_amt[9]  = 4'd0;  v_op[9]  = 2'b11; v_exp[9]  = 9'h0AA;
    v_data[10] = 9'h1FF; v_amt[10] = 4'd9;  v_op[10] = 2'b10; v_exp[10] = 9'h000;

    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_amt = '0;
    in_op = '0;
    out_ready = 1'b0;

    // Reset values, before any clock edge.
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_out_data", out_data, 0);

    step();
    step();
    #3 rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", in_ready, 0);
    step();
    chk("rel_in_ready_first_edge", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // Back-to-back shift vectors with out_ready high: each result one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_data  = v_data[i];
      in_amt   = v_amt[i];
      in_op    = v_op[i];
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, v_exp[i]);
    end
    in_valid = 1'b0;
    step();
    chk("vec_drain_valid", out_valid, 0);
    chk("vec_ops_done", ops_done, 11);

    // Stalled output: two accepted, third held off, then in-order drain.
    out_ready = 1'b0;
    in_amt = 4'd0;
    in_op = 2'b00;
    in_valid = 1'b1;
    in_data = 9'h011;
    step();
    chk("stall_rdy_after_1", in_ready, 1);
    chk("stall_head_1", out_data, 9'h011);
    in_data = 9'h022;
    step();
    chk("stall_rdy_after_2", in_ready, 0);
    chk("stall_head_2", out_data, 9'h011);
    in_data = 9'h033;
    step();
    chk("stall_rdy_held", in_ready, 0);
    chk("stall_head_stable", out_data, 9'h011);
    out_ready = 1'b1;
    step();
    chk("drain_pop1_data", out_data, 9'h022);
    chk("drain_rdy_after_pop1", in_ready, 1);
    step();
    chk("drain_pop2_data", out_data, 9'h033);
    in_valid = 1'b0;
    step();
    chk("drain_empty", out_valid, 0);
    chk("drain_ops_done", ops_done, 14);

    // Flush while FULL with an operand offered: nothing accepted, ops_done kept.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 9'h044;
    step();
    in_data = 9'h055;
    step();
    chk("flush_pre_full", in_ready, 0);
    flush = 1'b1;
    in_data = 9'h066;
    #1;
    chk("flush_in_ready_low", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_ops_done", ops_done, 14);
    chk("flush_in_ready_back", in_ready, 1);
    in_valid = 1'b1;
    in_data = 9'h077;
    in_amt = 4'd1;
    step();
    in_valid = 1'b0;
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_data", out_data, 9'h0EE);
    out_ready = 1'b1;
    step();
    chk("post_flush_ops", ops_done, 15);
    chk("post_flush_empty", out_valid, 0);

    // Flush coinciding with a pop: the pop still counts.
    out_ready = 1'b0;
    in_amt = 4'd0;
    in_valid = 1'b1;
    in_data = 9'h088;
    step();
    in_data = 9'h099;
    step();
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_pop_ops", ops_done, 16);
    chk("flush_pop_empty", out_valid, 0);

    // Sustained stream: one result per cycle, counter saturates without wrapping.
    errs = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_amt = 4'd0;
    for (int i = 0; i < 70000; i++) begin
      in_data = 9'(i);
      in_op = 2'(i);
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 9'(i)) errs++;
      if (i == 999) chk("stream_ops_mid", ops_done, 1015);
      if (i == 65518) chk("stream_ops_fffe", ops_done, 16'hFFFE);
      if (i == 65519) chk("stream_ops_sat", ops_done, 16'hFFFF);
    end
    in_valid = 1'b0;
    step();
    chk("stream_errs", errs, 0);
    chk("stream_ops_final", ops_done, 16'hFFFF);
    chk("stream_empty", out_valid, 0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 9'h101;
    step();
    in_data = 9'h102;
    step();
    in_valid = 1'b0;
    chk("arst_pre_full_valid", out_valid, 1);
    chk("arst_pre_full_rdy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_ops_done", ops_done, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_data", out_data, 0);
    step();
    step();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("arst_rel_rdy", in_ready, 1);
    chk("arst_rel_valid", out_valid, 0);
    step();
    chk("arst_rel_valid2", out_valid, 0);
    chk("arst_rel_ops", ops_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
